// File: rtl/uart_rom_load_controller_pkg.sv
// Shared definitions for the UART ROM-load controller.
//   - Default frame sync byte and UART response bytes
//   - FSM state and sticky status encodings
//   - Echo-byte helper
package uart_rom_load_controller_pkg;

  localparam logic [7:0] SYNC_DEFAULT  = 8'hA5;
  localparam logic [7:0] RESP_OK       = 8'h4B;
  localparam logic [7:0] RESP_CSUM     = 8'h45;
  localparam logic [7:0] RESP_TIMEOUT  = 8'h54;
  localparam logic [7:0] RESP_ABORT    = 8'h4F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHECK
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_CSUM    = 2'b01,
    STAT_TIMEOUT = 2'b10,
    STAT_ABORT   = 2'b11
  } status_t;

  // Echo returned per written word: top and bottom nibble of the word.
  function automatic logic [7:0] echo_of(input logic [15:0] word);
    return {word[15:12], word[3:0]};
  endfunction

endpackage

// File: rtl/uart_rom_load_controller_timeout.sv
// rom_load_timeout: inter-byte watchdog for the ROM-load frame.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   restart  in   clears the count (a byte arrived)
//   enable   in   count only while high; count is cleared while low
//   expired  out  single-cycle pulse on the TIMEOUT_CYCLES-th enabled cycle
//                 without a restart
module rom_load_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 25_125_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // A restart in the same cycle suppresses expiry: the byte wins.
  assign expired = enable && !restart && (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n || restart || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rom_load_controller.sv
// uart_rom_load_controller: frame sequencer between the UART byte stream and
// the hack_soc ROM-loader port.
// Frame: SYNC, count hi, count lo, N big-endian words, XOR checksum of data bytes.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   rx_received/rx_byte/rx_error UART receive side
//   tx_busy, tx_transmit/tx_byte UART transmit side (1-entry response slot)
//   rom_loader_load/sck/data/ack ROM write handshake to hack_soc
//   hack_external_reset          CPU hold-in-reset (load delayed one cycle)
//   busy                         high whenever not idle
//   status                       sticky: 00 ok, 01 checksum, 10 timeout, 11 overrun/rx error
module uart_rom_load_controller
  import uart_rom_load_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25_125_000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_received,
  input  logic [7:0]  rx_byte,
  input  logic        rx_error,
  input  logic        tx_busy,
  output logic        tx_transmit,
  output logic [7:0]  tx_byte,
  output logic        rom_loader_load,
  output logic        rom_loader_sck,
  output logic [15:0] rom_loader_data,
  input  logic        rom_loader_ack,
  output logic        hack_external_reset,
  output logic        busy,
  output logic [1:0]  status
);

  state_t      state;
  status_t     status_q;
  logic [15:0] remaining;
  logic [7:0]  hi_byte;
  logic [7:0]  csum;
  logic [7:0]  chk_byte;
  logic        chk_pending;
  logic        slot_full;
  logic [7:0]  slot_byte;
  logic        timeout_expired;

  logic        abort_req;
  logic [7:0]  abort_byte;
  status_t     abort_code;

  logic        slot_draining;
  logic        ack_fire;

  assign status = status_q;

  rom_load_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (rx_received),
    .enable  (busy),
    .expired (timeout_expired)
  );

  // The slot is handed to the UART only when it is idle and no pulse was
  // issued last cycle (tx_busy may lag tx_transmit by one cycle).
  assign slot_draining = slot_full && !tx_busy && !tx_transmit;
  assign ack_fire      = rom_loader_sck && rom_loader_ack;

  // Abort priority: rx error, then timeout, then overrun (a low byte that
  // would complete a word while the previous word is still strobed).
  always_comb begin
    abort_req  = 1'b0;
    abort_byte = RESP_ABORT;
    abort_code = STAT_ABORT;
    if (state != ST_IDLE && rx_error) begin
      abort_req = 1'b1;
    end else if (timeout_expired) begin
      abort_req  = 1'b1;
      abort_byte = RESP_TIMEOUT;
      abort_code = STAT_TIMEOUT;
    end else if (state == ST_DATA_LO && rx_received && rom_loader_sck) begin
      abort_req = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state               <= ST_IDLE;
      status_q            <= STAT_OK;
      remaining           <= '0;
      hi_byte             <= '0;
      csum                <= '0;
      chk_byte            <= '0;
      chk_pending         <= 1'b0;
      slot_full           <= 1'b0;
      slot_byte           <= '0;
      tx_transmit         <= 1'b0;
      tx_byte             <= '0;
      rom_loader_load     <= 1'b0;
      rom_loader_sck      <= 1'b0;
      rom_loader_data     <= '0;
      hack_external_reset <= 1'b1;
      busy                <= 1'b0;
    end else begin
      hack_external_reset <= rom_loader_load;
      tx_transmit         <= 1'b0;

      if (slot_draining) begin
        tx_transmit <= 1'b1;
        tx_byte     <= slot_byte;
        slot_full   <= 1'b0;
      end

      // Word accepted by hack_soc: release strobe, queue echo if the slot
      // is (or is becoming) free.
      if (ack_fire) begin
        rom_loader_sck <= 1'b0;
        if (!slot_full || slot_draining) begin
          slot_full <= 1'b1;
          slot_byte <= echo_of(rom_loader_data);
        end
      end

      // Status responses are written last so they overwrite a pending echo.
      if (abort_req) begin
        rom_loader_sck  <= 1'b0;
        rom_loader_load <= 1'b0;
        busy            <= 1'b0;
        chk_pending     <= 1'b0;
        state           <= ST_IDLE;
        slot_full       <= 1'b1;
        slot_byte       <= abort_byte;
        status_q        <= abort_code;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (rx_received && rx_byte == SYNC_BYTE) begin
              rom_loader_load <= 1'b1;
              busy            <= 1'b1;
              csum            <= '0;
              chk_pending     <= 1'b0;
              status_q        <= STAT_OK;
              state           <= ST_CNT_HI;
            end
          end
          ST_CNT_HI: begin
            if (rx_received) begin
              remaining[15:8] <= rx_byte;
              state           <= ST_CNT_LO;
            end
          end
          ST_CNT_LO: begin
            if (rx_received) begin
              remaining[7:0] <= rx_byte;
              state <= ({remaining[15:8], rx_byte} == 16'd0) ? ST_CHECK : ST_DATA_HI;
            end
          end
          ST_DATA_HI: begin
            if (rx_received) begin
              hi_byte <= rx_byte;
              state   <= ST_DATA_LO;
            end
          end
          ST_DATA_LO: begin
            // sck is known low here; a high sck takes the overrun abort path.
            if (rx_received) begin
              rom_loader_data <= {hi_byte, rx_byte};
              rom_loader_sck  <= 1'b1;
              csum            <= csum ^ hi_byte ^ rx_byte;
              if (remaining != 16'd0) begin
                remaining <= remaining - 16'd1;
              end
              state <= (remaining <= 16'd1) ? ST_CHECK : ST_DATA_HI;
            end
          end
          ST_CHECK: begin
            // The checksum byte is parked until the last strobe has dropped.
            if (chk_pending && !rom_loader_sck) begin
              slot_full       <= 1'b1;
              slot_byte       <= (chk_byte == csum) ? RESP_OK : RESP_CSUM;
              status_q        <= (chk_byte == csum) ? STAT_OK : STAT_CSUM;
              rom_loader_load <= 1'b0;
              busy            <= 1'b0;
              chk_pending     <= 1'b0;
              state           <= ST_IDLE;
            end else if (rx_received && !chk_pending) begin
              chk_byte    <= rx_byte;
              chk_pending <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rom_load_controller.sv
module tb_uart_rom_load_controller;

  localparam int unsigned TO  = 100;
  localparam int unsigned GAP = 30;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_received = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_error = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_transmit;
  logic [7:0]  tx_byte;
  logic        rom_loader_load;
  logic        rom_loader_sck;
  logic [15:0] rom_loader_data;
  logic        rom_loader_ack = 1'b0;
  logic        hack_external_reset;
  logic        busy;
  logic [1:0]  status;

  always #5 clk = ~clk;

  uart_rom_load_controller #(
    .TIMEOUT_CYCLES(TO),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .rx_received         (rx_received),
    .rx_byte             (rx_byte),
    .rx_error            (rx_error),
    .tx_busy             (tx_busy),
    .tx_transmit         (tx_transmit),
    .tx_byte             (tx_byte),
    .rom_loader_load     (rom_loader_load),
    .rom_loader_sck      (rom_loader_sck),
    .rom_loader_data     (rom_loader_data),
    .rom_loader_ack      (rom_loader_ack),
    .hack_external_reset (hack_external_reset),
    .busy                (busy),
    .status              (status)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- environment models (negedge) ----------------
  logic [15:0] word_log[$];
  logic [7:0]  tx_log[$];
  bit          stall_ack = 1'b0;
  int unsigned sck_cyc = 0;
  int unsigned txb_cnt = 0;
  logic        prev_sck = 1'b0;
  logic        prev_load = 1'b0;
  logic        prev_rst = 1'b0;
  logic [15:0] data_at_rise = '0;
  int unsigned stab_err = 0;
  int unsigned hx_err = 0;
  bit          load_seen = 1'b0;
  bit          hack_seen = 1'b0;

  always @(negedge clk) begin
    // hack_soc: ack three cycles after strobe rises, released when strobe drops
    if (!rom_loader_sck) begin
      sck_cyc = 0;
      rom_loader_ack = 1'b0;
    end else begin
      sck_cyc++;
      if (sck_cyc == 3 && !stall_ack) rom_loader_ack = 1'b1;
    end
    // UART transmitter: busy for 8 cycles after each pulse
    if (tx_transmit) begin
      tx_log.push_back(tx_byte);
      tx_busy = 1'b1;
      txb_cnt = 8;
    end else if (txb_cnt > 0) begin
      txb_cnt--;
      if (txb_cnt == 0) tx_busy = 1'b0;
    end
    // ROM word capture and strobe-stability
    if (rom_loader_sck && !prev_sck) begin
      word_log.push_back(rom_loader_data);
      data_at_rise = rom_loader_data;
    end else if (rom_loader_sck && rom_loader_data !== data_at_rise) begin
      stab_err++;
    end
    // CPU reset follows load by one cycle
    if (prev_rst && hack_external_reset !== prev_load) hx_err++;
    if (rom_loader_load) load_seen = 1'b1;
    if (hack_external_reset && reset_n) hack_seen = 1'b1;
    prev_sck  = rom_loader_sck;
    prev_load = rom_loader_load;
    prev_rst  = reset_n;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte = b; rx_received = 1'b1;
    @(posedge clk); #1;
    rx_received = 1'b0;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic pulse_error();
    @(posedge clk); #1;
    rx_error = 1'b1;
    @(posedge clk); #1;
    rx_error = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned waited = 0;
    while (busy && waited < 4 * TO) begin
      @(negedge clk);
      waited++;
    end
    check(tag, {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
  endtask

  // ---------------- frame-level reference model ----------------
  logic [7:0]  frame_q[$];
  logic [15:0] exp_words[$];
  logic [7:0]  exp_tx[$];
  logic [1:0]  exp_status;

  // Only the first `sent` bytes of frame_q reach the DUT; `err` means an rx
  // error follows them, otherwise an incomplete frame ends by timeout.
  task automatic model_frame(input int sent, input bit err);
    int n;
    logic [7:0] cs;
    logic [15:0] w;
    exp_words.delete();
    exp_tx.delete();
    cs = 8'h00;
    n = (sent >= 3) ? int'({frame_q[1], frame_q[2]}) : 0;
    for (int i = 0; i < n; i++) begin
      if (3 + 2 * i + 1 < sent) begin
        w = {frame_q[3 + 2 * i], frame_q[4 + 2 * i]};
        exp_words.push_back(w);
        exp_tx.push_back({w[15:12], w[3:0]});
        cs = cs ^ w[15:8] ^ w[7:0];
      end
    end
    if (sent >= 3 && sent >= 3 + 2 * n + 1) begin
      if (frame_q[3 + 2 * n] == cs) begin
        exp_tx.push_back(8'h4B); exp_status = 2'b00;
      end else begin
        exp_tx.push_back(8'h45); exp_status = 2'b01;
      end
    end else if (err) begin
      exp_tx.push_back(8'h4F); exp_status = 2'b11;
    end else begin
      exp_tx.push_back(8'h54); exp_status = 2'b10;
    end
  endtask

  task automatic compare_logs(input string tag);
    check({tag, ".nwords"}, word_log.size(), exp_words.size());
    for (int i = 0; i < exp_words.size() && i < word_log.size(); i++)
      check({tag, ".word"}, {16'd0, word_log[i]}, {16'd0, exp_words[i]});
    check({tag, ".ntx"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      check({tag, ".tx"}, {24'd0, tx_log[i]}, {24'd0, exp_tx[i]});
  endtask

  task automatic run_frame(input string tag, input int sent, input bit err);
    word_log.delete();
    tx_log.delete();
    load_seen = 1'b0;
    hack_seen = 1'b0;
    for (int i = 0; i < sent; i++) send_byte(frame_q[i]);
    if (err) pulse_error();
    wait_idle({tag, ".idle"});
    model_frame(sent, err);
    compare_logs(tag);
    check({tag, ".status"}, {30'd0, status}, {30'd0, exp_status});
    check({tag, ".load"}, {31'd0, rom_loader_load}, 32'd0);
    check({tag, ".sck"}, {31'd0, rom_loader_sck}, 32'd0);
    check({tag, ".hackrst"}, {31'd0, hack_external_reset}, 32'd0);
    check({tag, ".load_seen"}, {31'd0, load_seen}, 32'd1);
    check({tag, ".hack_seen"}, {31'd0, hack_seen}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".tx_transmit"}, {31'd0, tx_transmit}, 32'd0);
    check({tag, ".tx_byte"}, {24'd0, tx_byte}, 32'd0);
    check({tag, ".load"}, {31'd0, rom_loader_load}, 32'd0);
    check({tag, ".sck"}, {31'd0, rom_loader_sck}, 32'd0);
    check({tag, ".data"}, {16'd0, rom_loader_data}, 32'd0);
    check({tag, ".hackrst"}, {31'd0, hack_external_reset}, 32'd1);
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".status"}, {30'd0, status}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned mode;
    int          sent;
    bit          err;
    logic [15:0] nw;
    logic [15:0] w;
    logic [7:0]  cs;
    int unsigned tx_before;

    // 1. reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.hack_release", {31'd0, hack_external_reset}, 32'd0);
    repeat (5) @(posedge clk);

    // 2. two-word frame, good checksum
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_frame("good2", 8, 1'b0);

    // 3. bad checksum
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_frame("badcs", 8, 1'b0);

    // 4. zero-length frame
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("empty", 4, 1'b0);

    // 5. truncated frame -> timeout
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12};
    run_frame("tmo", 4, 1'b0);
    check("tmo.busy", {31'd0, busy}, 32'd0);

    // randomized frames, with idle noise in front
    for (int it = 0; it < 20; it++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        logic [7:0] junk;
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk);
      end
      if ($urandom_range(0, 3) == 0) pulse_error();
      n = $urandom_range(0, 3);
      nw = 16'(n);
      frame_q.delete();
      frame_q.push_back(8'hA5);
      frame_q.push_back(nw[15:8]);
      frame_q.push_back(nw[7:0]);
      cs = 8'h00;
      for (int i = 0; i < int'(n); i++) begin
        w = 16'($urandom_range(0, 65535));
        frame_q.push_back(w[15:8]);
        frame_q.push_back(w[7:0]);
        cs = cs ^ w[15:8] ^ w[7:0];
      end
      if ($urandom_range(0, 1) == 1) cs = cs ^ 8'($urandom_range(1, 255));
      frame_q.push_back(cs);
      mode = $urandom_range(0, 3);
      sent = frame_q.size();
      err = 1'b0;
      if (mode >= 2) begin
        sent = int'($urandom_range(1, frame_q.size() - 1));
        err = (mode == 3);
      end
      run_frame("rand", sent, err);
    end

    // 6. stalled ack then overrun
    stall_ack = 1'b1;
    word_log.delete();
    tx_log.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    wait_idle("ovr.idle");
    stall_ack = 1'b0;
    check("ovr.nwords", word_log.size(), 1);
    if (word_log.size() > 0) check("ovr.word", {16'd0, word_log[0]}, 32'h1234);
    check("ovr.ntx", tx_log.size(), 1);
    if (tx_log.size() > 0) check("ovr.tx", {24'd0, tx_log[0]}, 32'h4F);
    check("ovr.status", {30'd0, status}, 32'd3);
    check("ovr.sck", {31'd0, rom_loader_sck}, 32'd0);

    // reset in the middle of a new frame
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    tx_before = tx_log.size();
    check("mid.busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("mid");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("mid.no_tx", tx_log.size(), tx_before);
    check("mid.busy", {31'd0, busy}, 32'd0);
    check("mid.status", {30'd0, status}, 32'd0);
    check("mid.load", {31'd0, rom_loader_load}, 32'd0);

    check("data_stable", stab_err, 0);
    check("hack_follows_load", hx_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
